// File: rtl/image_pkg.sv
// Shared constants and types for the image-RAM readback block.
package image_pkg;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 12;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

    // Bit position within the packed word for the c-th captured pixel.
    function automatic logic [4:0] pack_index(input logic [4:0] c, input logic order);
        return (order == ORDER_MSB_FIRST) ? ~c : c;
    endfunction

endpackage

// File: rtl/image_readback_if.sv
// Custom-instruction command/result signals plus the shared RAM read port.
interface image_readback_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
);
    logic              start;
    logic [31:0]       dataa;
    logic [31:0]       datab;
    logic [WORD_W-1:0] result;
    logic              done;
    logic              busy;
    logic              rd_req;
    logic              rd_grant;
    logic [ADDR_W-1:0] rdaddress;
    logic              q;

    // Environment side: issues commands, arbitrates and owns the RAM.
    modport master (
        output start, dataa, datab, rd_grant, q,
        input  result, done, busy, rd_req, rdaddress
    );

    // Readback block side.
    modport slave (
        input  start, dataa, datab, rd_grant, q,
        output result, done, busy, rd_req, rdaddress
    );
endinterface

// File: rtl/read_valid_pipe.sv
// Shift register of issue flags; its output marks the cycle when q holds
// the data for an issued read.
module read_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    output logic vld_o
);
    logic [RD_LAT-1:0] pipe_q;
    logic [RD_LAT-1:0] pipe_d;

    assign pipe_d = RD_LAT'({pipe_q, push_i});
    assign vld_o  = pipe_q[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end
endmodule

// File: rtl/image_readback.sv
// Fetches 32 consecutive 1-bit pixels from the image RAM through a
// request/grant read port and packs them into one word.
module image_readback #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    image_readback_if.slave bus
);
    import image_pkg::*;

    localparam logic [4:0] LAST = 5'(WORD_W - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
    logic [4:0]        issue_cnt_q, issue_cnt_d;
    logic [4:0]        cap_cnt_q, cap_cnt_d;
    logic              order_q, order_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rd_req_q, rd_req_d;
    logic              issue;
    logic              push;
    logic              cap_vld;
    logic              unused_bits;

    assign unused_bits = ^{bus.dataa[31:ADDR_W-5], bus.datab[31:1]};
    assign issue       = rd_req_q & bus.rd_grant;

    read_valid_pipe #(.RD_LAT(RD_LAT)) u_vld (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .vld_o  (cap_vld)
    );

    always_comb begin
        state_d     = state_q;
        rdaddress_d = rdaddress_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        order_d     = order_q;
        result_d    = result_q;
        done_d      = done_q;
        busy_d      = busy_q;
        rd_req_d    = rd_req_q;
        push        = 1'b0;

        // Captures run independently of the grant so in-flight reads land.
        if (cap_vld) begin
            result_d[pack_index(cap_cnt_q, order_q)] = bus.q;
            cap_cnt_d = cap_cnt_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rdaddress_d = {bus.dataa[ADDR_W-6:0], 5'b0};
                    order_d     = bus.datab[0];
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    result_d    = '0;
                    busy_d      = 1'b1;
                    rd_req_d    = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    push        = 1'b1;
                    issue_cnt_d = issue_cnt_q + 5'd1;
                    // Address stays on the last pixel so a top-row word never wraps.
                    if (issue_cnt_q == LAST) begin
                        rd_req_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end else begin
                        rdaddress_d = rdaddress_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cap_vld && cap_cnt_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rdaddress_q <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            order_q     <= ORDER_LSB_FIRST;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdaddress_q <= rdaddress_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            order_q     <= order_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_req_q    <= rd_req_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rdaddress = rdaddress_q;
endmodule
